// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester driven by a valid/ready command port.
// It sequences IDLE -> SETUP -> ACCESS, honours PREADY wait states and aborts an
// ACCESS that waits too long. Each finished transfer gives one rsp_valid pulse.
module apb_master #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    // Last counter value before the abort; TIMEOUT is limited to 1..255.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              in_access, expire, done, accept;

    // Completion/abort decode and next-state logic.
    always_comb begin
        in_access = (state_q == StAccess);
        expire    = in_access && !PREADY && (cnt_q == CntLast);
        done      = in_access && (PREADY || expire);
        cmd_ready = (state_q == StIdle) || done;
        accept    = cmd_valid && cmd_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = 8'd0;
            end
            StAccess: begin
                if (done) begin
                    // A command taken on the completing edge goes straight to SETUP.
                    state_d = accept ? StSetup : StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // APB phase outputs are decoded from the state.
    always_comb begin
        PSEL    = (state_q != StIdle);
        PENABLE = in_access;
    end

    // State and wait-counter registers.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command capture; the bus fields hold until the next accepted command.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
        end
    end

    // Response strobe and fields, loaded only on the completing/aborting edge.
    always_ff @(posedge PCLK) begin
        if (RST) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= done;
            if (done) begin
                rsp_timeout_q <= expire;
                rsp_err_q     <= expire || PSLVERR;
                rsp_rdata_q   <= (expire || pwrite_q) ? '0 : PRDATA;
            end
        end
    end

    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
